edge_event_arbiter: RTL

//   Multi-channel front end for the Moore edge detector. Synchronises N_CH raw

---
 rtl/edge_event_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge front end: synchronisers, Moore edge FSMs,
// pending-event latches and a round-robin valid/ready event port.
module edge_event_arbiter #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  level,
  input  logic [N_CH-1:0]  enable,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_ch,
  output logic [N_CH-1:0]  pending,
  output logic             overrun,
  input  logic             overrun_clr
);

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    EDGE = 2'd1,
    ONE  = 2'd2
  } state_t;

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  s;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  set;
  logic [N_CH-1:0]  gnt;
  logic [N_CH-1:0]  gnt_eff;
  logic [N_CH-1:0]  pend_nxt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] ptr;
  logic             found;
  logic             slot_free;
  logic             load;
  logic             ovr_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < SYNC_STAGES; j++)
        sync_q[j] <= '0;
    end else begin
      sync_q[0] <= level;
      for (int j = 1; j < SYNC_STAGES; j++)
        sync_q[j] <= sync_q[j-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t st;

    always_ff @(posedge clk) begin
      if (reset) begin
        st <= ZERO;
      end else begin
        unique case (st)
          ZERO: if (s[i]) st <= EDGE;
          EDGE: st <= s[i] ? ONE : ZERO;
          ONE:  if (!s[i]) st <= ZERO;
          default: st <= ZERO;
        endcase
      end
    end

    assign tick[i] = (st == EDGE);
  end

  assign set       = tick & enable;
  assign slot_free = !evt_valid || evt_ready;

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int d = 1; d <= N_CH; d++) begin
      cand = IDX_W'((int'(ptr) + d) % N_CH);
      if (!found && pending[cand]) begin
        found        = 1'b1;
        gnt_idx      = cand;
        gnt[cand]    = 1'b1;
      end
    end
  end

  assign load     = slot_free && found;
  assign gnt_eff  = load ? gnt : '0;
  // A new tick outranks the grant clear; disabling drops the event.
  assign pend_nxt = ((pending & ~gnt_eff) | set) & enable;
  assign ovr_set  = |(set & pending & ~gnt_eff);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      overrun   <= 1'b0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      ptr       <= IDX_W'(N_CH - 1);
    end else begin
      pending <= pend_nxt;
      if (ovr_set)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
      if (slot_free) begin
        evt_valid <= found;
        if (found) begin
          evt_ch <= gnt_idx;
          ptr    <= gnt_idx;
        end
      end
    end
  end

endmodule
